ahb_slave_mem: RTL and testbench
================================

# ahb_slave_mem

AHB-Lite memory slave that responds to transfers issued by the FreeAHB master, providing a target with programmable and dynamically forced wait states plus two-cycle ERROR responses. It sits on the slave side of the bus behind the decoder and mux. It is the component used to exercise the master's stall and skid-buffer paths in simulation and on FPGA.

## Interface
- DW, 32: data width (32 or 64).
- DEPTH, 256: memory depth in DW-bit words.
- WAIT_STATES, 0: fixed wait cycles inserted in every valid data phase (0..15).

- i_clk  in  1  bus clock (HCLK); all state on rising edge.
- i_resetn  in  1  reset, asynchronous, active-low.
- i_hsel  in  1  slave select from decoder.
- i_haddr  in  32  byte address.
- i_htrans  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- i_hwrite  in  1  1=write.
- i_hsize  in  3  0=byte, 1=half, 2=word, 3=dword.
- i_hburst  in  3  accepted, ignored.
- i_hwdata  in  DW  write data (data phase).
- i_hready  in  1  bus HREADY (mux output).
- i_force_wait  in  1  when high during a valid data phase, holds o_hreadyout low.
- o_hreadyout  out  1  slave ready.
- o_hresp  out  1  0=OKAY, 1=ERROR.
- o_hrdata  out  DW  read data.

## Operation
- Address phase sampled only when i_hsel & i_hready; it is valid if i_htrans is NONSEQ or SEQ. Register addr_q, write_q, size_q.
- Error check at sample time: ERROR if haddr >= DEPTH*(DW/8), i_hsize > log2(DW/8), or haddr not aligned to 2^hsize.
- States: IDLE, WAIT, ERR1, ERR2.
  - IDLE: o_hreadyout=1, o_hresp=0. Valid OK sample -> WAIT if WAIT_STATES>0 (counter loaded WAIT_STATES), otherwise stay (data phase completes next cycle). Valid error sample -> ERR1. IDLE/BUSY/unselected -> zero-wait OKAY, no access.
  - WAIT: o_hreadyout=0 and the counter decrements. Leave to the completing cycle when the counter reaches 0 and i_force_wait=0.
  - ERR1: o_hreadyout=0, o_hresp=1 -> ERR2.
  - ERR2: o_hreadyout=1, o_hresp=1; a new address may be sampled here -> IDLE/WAIT/ERR1.
- i_force_wait is also honoured in the zero-wait completion cycle: it holds o_hreadyout low and the slave waits in WAIT with counter 0. It is ignored in IDLE (no pending phase), ERR1 and ERR2.
- Write commits in the cycle the data phase completes (o_hreadyout=1, OKAY): byte lanes enabled per size_q/addr_q low bits, little-endian. Other lanes unchanged. ERROR transfers never write.
- Read: o_hrdata = mem[addr_q word index], full word with all lanes, combinational, during a read data phase; otherwise 0.
- Back-to-back write then read of the same word: the read data phase returns the newly written data.
- Memory reset to all zeros.

## Timing
- Reset values: o_hreadyout=1, o_hresp=0, o_hrdata=0, state IDLE, memory zero.
- Reset asserted mid-transfer aborts it immediately. A pending write is dropped.
- Data-phase length: OKAY = 1 + WAIT_STATES + forced-wait cycles; ERROR = exactly 2.
- A new address phase is accepted in the completing cycle of the previous data phase (pipelined). No bubble.

## Test plan
- Reset, WAIT_STATES=0: NONSEQ word write 0xDEADBEEF @0x10, then NONSEQ read @0x10 -> o_hreadyout stays 1; read data phase o_hrdata=0xDEADBEEF.
- Byte write 0xAA @0x13 over word 0x11223344 @0x10 -> read returns 0xAA223344. Halfword 0x5566 @0x12 -> 0x55663344.
- WAIT_STATES=3, four-beat SEQ read burst -> each beat shows 3 cycles o_hreadyout=0 then 1. Data correct per beat.
- Read @DEPTH*4 (out of range) -> cycle1 hreadyout=0/hresp=1, cycle2 hreadyout=1/hresp=1. Word write @0x02 (misaligned) -> same response, memory unchanged.
- i_force_wait high for 5 cycles during a zero-wait write -> o_hreadyout low for exactly those 5 cycles. Write commits only on the release cycle.
- i_resetn pulsed low during a WAIT cycle of a write -> outputs return to reset values asynchronously, target word reads 0 afterwards.

Source files
------------

// File: rtl/ahb_slave_mem.sv
// rtl/ahb_slave_mem.sv - AHB-Lite memory slave with programmable/forced wait states and ERROR responses
// Byte-addressed little-endian memory; data phases stretch by WAIT_STATES plus any forced-wait cycles.
module ahb_slave_mem #(
  parameter int DW          = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic          i_clk,
  input  logic          i_resetn,
  input  logic          i_hsel,
  input  logic [31:0]   i_haddr,
  input  logic [1:0]    i_htrans,
  input  logic          i_hwrite,
  input  logic [2:0]    i_hsize,
  input  logic [2:0]    i_hburst,
  input  logic [DW-1:0] i_hwdata,
  input  logic          i_hready,
  input  logic          i_force_wait,
  output logic          o_hreadyout,
  output logic          o_hresp,
  output logic [DW-1:0] o_hrdata
);
  localparam int NB = DW / 8;
  localparam int LW = $clog2(NB);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int AW = LW + IW;
  localparam logic [31:0] MEM_BYTES = 32'(DEPTH * NB);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_t;

  state_t        state_q;
  logic [3:0]    cnt_q;
  logic [AW-1:0] addr_q;
  logic          write_q;
  logic [2:0]    size_q;
  logic [DW-1:0] mem_q [DEPTH];

  logic          sample;
  logic          err;
  logic          done;
  logic          wr_en;
  logic [IW-1:0] idx;
  logic [NB-1:0] lane_en;
  logic          unused_in;

  assign unused_in = ^{i_hburst, i_htrans[0]};

  assign sample = i_hsel & i_hready & i_htrans[1];
  assign err    = (i_haddr >= MEM_BYTES) | (i_hsize > 3'(LW)) |
                  ((i_haddr & ((32'd1 << i_hsize) - 32'd1)) != 32'd0);

  // S_WAIT covers every OK data phase; it completes once the counter is spent and nobody forces a stall
  assign done        = (state_q == S_WAIT) & (cnt_q == 4'd0) & ~i_force_wait;
  assign o_hreadyout = (state_q == S_IDLE) | (state_q == S_ERR2) | done;
  assign o_hresp     = (state_q == S_ERR1) | (state_q == S_ERR2);

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= 3'd0;
    end else if (state_q == S_ERR1) begin
      state_q <= S_ERR2;
    end else if (state_q == S_WAIT && !done) begin
      if (cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
    end else if (sample) begin
      addr_q  <= i_haddr[AW-1:0];
      write_q <= i_hwrite;
      size_q  <= i_hsize;
      if (err) begin
        state_q <= S_ERR1;
      end else begin
        state_q <= S_WAIT;
        cnt_q   <= 4'(WAIT_STATES);
      end
    end else begin
      state_q <= S_IDLE;
    end
  end

  assign idx   = addr_q[AW-1:LW];
  assign wr_en = done & write_q;

  // Lane i belongs to the transfer when it shares the size-aligned container with the address
  always_comb begin
    lane_en = '0;
    for (int i = 0; i < NB; i++) begin
      lane_en[i] = ((LW'(i) >> size_q) == (addr_q[LW-1:0] >> size_q));
    end
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      for (int w = 0; w < DEPTH; w++) mem_q[w] <= '0;
    end else if (wr_en) begin
      for (int b = 0; b < NB; b++) begin
        if (lane_en[b]) mem_q[idx][8*b +: 8] <= i_hwdata[8*b +: 8];
      end
    end
  end

  assign o_hrdata = (state_q == S_WAIT && !write_q) ? mem_q[idx] : '0;

endmodule

// File: tb/tb_ahb_slave_mem.sv
// tb/tb_ahb_slave_mem.sv - self-checking bench for ahb_slave_mem (zero-wait and 3-wait instances)
module tb_ahb_slave_mem;
  typedef struct {
    bit          wr;
    bit          seq;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    bit          exp_err;
    int          exp_wait;
    int          force_n;
  } xfer_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hsel0, hsel3;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize, hburst;
  logic [31:0] hwdata;
  logic        force_wait;
  logic        rdy0, resp0, rdy3, resp3;
  logic [31:0] rd0, rd3;

  int    checks = 0;
  int    errors = 0;
  xfer_t tab0[$], tab3[$], vec[$], sb[$];

  always #5 clk = ~clk;

  ahb_slave_mem #(.DW(32), .DEPTH(256), .WAIT_STATES(0)) dut0 (
    .i_clk(clk), .i_resetn(rst_n), .i_hsel(hsel0), .i_haddr(haddr), .i_htrans(htrans),
    .i_hwrite(hwrite), .i_hsize(hsize), .i_hburst(hburst), .i_hwdata(hwdata),
    .i_hready(rdy0), .i_force_wait(force_wait),
    .o_hreadyout(rdy0), .o_hresp(resp0), .o_hrdata(rd0)
  );

  ahb_slave_mem #(.DW(32), .DEPTH(256), .WAIT_STATES(3)) dut3 (
    .i_clk(clk), .i_resetn(rst_n), .i_hsel(hsel3), .i_haddr(haddr), .i_htrans(htrans),
    .i_hwrite(hwrite), .i_hsize(hsize), .i_hburst(hburst), .i_hwdata(hwdata),
    .i_hready(rdy3), .i_force_wait(force_wait),
    .o_hreadyout(rdy3), .o_hresp(resp3), .o_hrdata(rd3)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic xfer_t v(bit wr, bit seq, logic [2:0] size, logic [31:0] addr,
                              logic [31:0] wdata, logic [31:0] exp_rd, bit err, int wt, int fn);
    xfer_t x;
    x.wr = wr; x.seq = seq; x.size = size; x.addr = addr; x.wdata = wdata;
    x.exp_rd = exp_rd; x.exp_err = err; x.exp_wait = wt; x.force_n = fn;
    return x;
  endfunction

  // Pipelined master: address of i overlaps the data phase of i-1
  task automatic run_list(input bit use3);
    int          n;
    int          low;
    int          fn;
    bit          r, resp;
    logic [31:0] rd;
    xfer_t       e;
    n = vec.size();
    for (int i = 0; i <= n; i++) begin
      if (i < n) begin
        hsel0 = !use3; hsel3 = use3;
        htrans = vec[i].seq ? 2'd3 : 2'd2;
        haddr = vec[i].addr; hwrite = vec[i].wr; hsize = vec[i].size;
      end else begin
        hsel0 = 1'b0; hsel3 = 1'b0; htrans = 2'd0; haddr = 32'h0; hwrite = 1'b0; hsize = 3'd0;
      end
      fn = (i > 0) ? vec[i-1].force_n : 0;
      hwdata = (i > 0) ? vec[i-1].wdata : 32'h0;
      force_wait = (fn > 0);
      low = 0;
      forever begin
        @(negedge clk);
        r = use3 ? rdy3 : rdy0;
        resp = use3 ? resp3 : resp0;
        rd = use3 ? rd3 : rd0;
        if (r || low > 40) break;
        low++;
        if (i > 0 && sb.size() > 0) chk("resp_during_wait", 32'(resp), 32'(sb[0].exp_err));
        @(posedge clk); #1;
        force_wait = (low < fn);
      end
      if (i > 0 && sb.size() > 0) begin
        e = sb.pop_front();
        chk("wait_cycles", 32'(low), 32'(e.exp_wait));
        chk("hresp", 32'(resp), 32'(e.exp_err));
        chk("hrdata", rd, e.exp_rd);
      end else begin
        chk("idle_ready", 32'(r), 32'd1);
      end
      if (i < n) sb.push_back(vec[i]);
      @(posedge clk); #1;
      force_wait = 1'b0;
    end
    vec.delete();
  endtask

  initial begin
    //          wr seq sz addr        wdata         exp_rd        err wt fn
    tab0.push_back(v(1, 0, 2, 32'h010, 32'hDEADBEEF, 32'h0,        0, 0, 0));
    tab0.push_back(v(0, 0, 2, 32'h010, 32'h0,        32'hDEADBEEF, 0, 0, 0));
    tab0.push_back(v(1, 0, 2, 32'h010, 32'h11223344, 32'h0,        0, 0, 0));
    tab0.push_back(v(1, 0, 0, 32'h013, 32'hAABBCCDD, 32'h0,        0, 0, 0));
    tab0.push_back(v(0, 0, 2, 32'h010, 32'h0,        32'hAA223344, 0, 0, 0));
    tab0.push_back(v(1, 0, 1, 32'h012, 32'h55669988, 32'h0,        0, 0, 0));
    tab0.push_back(v(0, 0, 2, 32'h010, 32'h0,        32'h55663344, 0, 0, 0));
    tab0.push_back(v(0, 0, 2, 32'h400, 32'h0,        32'h0,        1, 1, 0));
    tab0.push_back(v(1, 0, 2, 32'h002, 32'hFFFFFFFF, 32'h0,        1, 1, 0));
    tab0.push_back(v(0, 0, 2, 32'h000, 32'h0,        32'h0,        0, 0, 0));
    tab0.push_back(v(1, 0, 2, 32'h020, 32'hCAFEF00D, 32'h0,        0, 5, 5));
    tab0.push_back(v(0, 0, 2, 32'h020, 32'h0,        32'hCAFEF00D, 0, 0, 0));
    tab0.push_back(v(0, 0, 3, 32'h018, 32'h0,        32'h0,        1, 1, 0));
    tab0.push_back(v(1, 0, 1, 32'h011, 32'hFFFFFFFF, 32'h0,        1, 1, 0));
    tab0.push_back(v(0, 0, 2, 32'h010, 32'h0,        32'h55663344, 0, 0, 0));
    tab0.push_back(v(1, 0, 2, 32'h3FC, 32'h0BADC0DE, 32'h0,        0, 0, 0));
    tab0.push_back(v(0, 0, 2, 32'h3FC, 32'h0,        32'h0BADC0DE, 0, 0, 0));

    tab3.push_back(v(1, 0, 2, 32'h040, 32'h11111111, 32'h0,        0, 3, 0));
    tab3.push_back(v(1, 1, 2, 32'h044, 32'h22222222, 32'h0,        0, 3, 0));
    tab3.push_back(v(1, 1, 2, 32'h048, 32'h33333333, 32'h0,        0, 3, 0));
    tab3.push_back(v(1, 1, 2, 32'h04C, 32'h44444444, 32'h0,        0, 3, 0));
    tab3.push_back(v(1, 0, 2, 32'h060, 32'h5A5A5A5A, 32'h0,        0, 3, 0));
    tab3.push_back(v(0, 0, 2, 32'h060, 32'h0,        32'h5A5A5A5A, 0, 3, 0));
    tab3.push_back(v(0, 0, 2, 32'h040, 32'h0,        32'h11111111, 0, 3, 0));
    tab3.push_back(v(0, 1, 2, 32'h044, 32'h0,        32'h22222222, 0, 3, 0));
    tab3.push_back(v(0, 1, 2, 32'h048, 32'h0,        32'h33333333, 0, 3, 0));
    tab3.push_back(v(0, 1, 2, 32'h04C, 32'h0,        32'h44444444, 0, 3, 0));
    tab3.push_back(v(0, 0, 2, 32'h400, 32'h0,        32'h0,        1, 1, 0));
    tab3.push_back(v(0, 0, 2, 32'h044, 32'h0,        32'h22222222, 0, 3, 0));

    rst_n = 1'b0; hsel0 = 1'b0; hsel3 = 1'b0; haddr = 32'h0; htrans = 2'd0;
    hwrite = 1'b0; hsize = 3'd0; hburst = 3'd0; hwdata = 32'h0; force_wait = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_hreadyout0", 32'(rdy0), 32'd1);
    chk("reset_hresp0", 32'(resp0), 32'd0);
    chk("reset_hrdata0", rd0, 32'h0);
    chk("reset_hreadyout3", 32'(rdy3), 32'd1);
    chk("reset_hresp3", 32'(resp3), 32'd0);
    chk("reset_hrdata3", rd3, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    vec = tab0;
    run_list(1'b0);

    hburst = 3'b011;
    vec = tab3;
    run_list(1'b1);
    hburst = 3'b000;

    // Reset pulse during a wait cycle of a write to 0x60
    hsel3 = 1'b1; htrans = 2'd2; haddr = 32'h060; hwrite = 1'b1; hsize = 3'd2;
    @(negedge clk);
    chk("rst_seq_addr_ready", 32'(rdy3), 32'd1);
    @(posedge clk); #1;
    hsel3 = 1'b0; htrans = 2'd0; hwdata = 32'h12345678;
    @(negedge clk);
    chk("rst_seq_in_wait", 32'(rdy3), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_hreadyout", 32'(rdy3), 32'd1);
    chk("async_reset_hresp", 32'(resp3), 32'd0);
    chk("async_reset_hrdata", rd3, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    vec.push_back(v(0, 0, 2, 32'h060, 32'h0, 32'h0, 0, 3, 0));
    vec.push_back(v(0, 0, 2, 32'h040, 32'h0, 32'h0, 0, 3, 0));
    run_list(1'b1);
    vec.push_back(v(0, 0, 2, 32'h010, 32'h0, 32'h0, 0, 0, 0));
    run_list(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
